// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write pacer.
// Contents: the pacer FSM state encoding, the HD44780 command bytes that need
// the long post-write delay, and a helper that classifies a request as long or short.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    // The controller ignores bit 0 of the home command, so 0x03 is also a home.
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME) ||
                       (data == LCD_CMD_HOME_ALT));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count.
// Ports:
//   clk, rst        clock and synchronous active-high reset (empties the queue)
//   push_i, wdata_i write request and data; ignored when full
//   pop_i           remove the head entry; ignored when empty
//   rdata_o         head entry (valid while empty_o=0)
//   full_o, empty_o occupancy flags
//   level_o         number of stored entries, 0..DEPTH
module sync_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lcd_write_pacer.sv
// Buffers LCD register writes from a fast bus and replays them to a slow
// LCD controller, leaving the controller's execution time between writes.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_wenable, in_rs, in_wdata bus write request (rs=0 command, rs=1 data)
//   in_ready                    queue not full
//   fifo_level                  queue occupancy
//   busy                        queue non-empty or a write in progress
//   overflow                    sticky: a write arrived while the queue was full
//   lcd_rs, lcd_wdata           register select and byte to the LCD controller
//   lcd_wenable                 one-cycle write strobe to the LCD controller
module lcd_write_pacer
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SHORT_WAIT = 2000,
    parameter int unsigned LONG_WAIT  = 76000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_wenable,
    input  logic                   in_rs,
    input  logic [7:0]             in_wdata,
    output logic                   in_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   lcd_rs,
    output logic [7:0]             lcd_wdata,
    output logic                   lcd_wenable
);

    localparam int unsigned MAX_WAIT = (LONG_WAIT > SHORT_WAIT) ? LONG_WAIT : SHORT_WAIT;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT) + 1;
    // The counter is loaded with wait-1 and counts down to zero, so the
    // WAIT state lasts exactly the requested number of cycles.
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_WAIT - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_WAIT - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [7:0]       lcd_wdata_q, lcd_wdata_d;
    logic             overflow_q, overflow_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       fifo_head;

    // Writes during reset are ignored rather than queued.
    assign fifo_push = in_wenable && !fifo_full && !rst;

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i ({in_rs, in_wdata}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_wdata_d = lcd_wdata_q;
        fifo_pop    = 1'b0;
        overflow_d  = overflow_q | (in_wenable & fifo_full);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                = 1'b1;
                    {lcd_rs_d, lcd_wdata_d} = fifo_head;
                    state_d                 = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = needs_long_wait(lcd_rs_q, lcd_wdata_q) ? LONG_LOAD : SHORT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lcd_rs_q    <= 1'b0;
            lcd_wdata_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_wdata_q <= lcd_wdata_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign busy        = !fifo_empty || (state_q != ST_IDLE);
    assign overflow    = overflow_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_wdata   = lcd_wdata_q;
    assign lcd_wenable = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_lcd_write_pacer.sv
// Scoreboard bench for lcd_write_pacer with SHORT_WAIT=4, LONG_WAIT=10, DEPTH=4.
// The driver queues the expected LCD writes (byte, spacing to the previous
// pulse, optional absolute cycle); the monitor pops and compares on each pulse.
module tb_lcd_write_pacer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SW    = 4;
    localparam int unsigned LW    = 10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_wenable = 1'b0;
    logic                   in_rs = 1'b0;
    logic [7:0]             in_wdata = '0;
    logic                   in_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   busy;
    logic                   overflow;
    logic                   lcd_rs;
    logic [7:0]             lcd_wdata;
    logic                   lcd_wenable;

    lcd_write_pacer #(
        .DEPTH      (DEPTH),
        .SHORT_WAIT (SW),
        .LONG_WAIT  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_wenable  (in_wenable),
        .in_rs       (in_rs),
        .in_wdata    (in_wdata),
        .in_ready    (in_ready),
        .fifo_level  (fifo_level),
        .busy        (busy),
        .overflow    (overflow),
        .lcd_rs      (lcd_rs),
        .lcd_wdata   (lcd_wdata),
        .lcd_wenable (lcd_wenable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;  // expected cycles since previous pulse, 0 = unchecked
        int         at;   // expected absolute cycle, -1 = unchecked
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors     = 0;
    int   checks     = 0;
    int   last_pulse = -1000;
    int   pulse_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (lcd_wenable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got rs=%0d data=0x%02h, expected no pulse (cycle %0d)",
                         lcd_rs, lcd_wdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_rs", int'(lcd_rs), int'(mon_e.rs));
                check("pulse_data", int'(lcd_wdata), int'(mon_e.data));
                if (mon_e.gap > 0) check("pulse_gap", cyc - last_pulse, mon_e.gap);
                if (mon_e.at >= 0) check("pulse_latency", cyc, mon_e.at);
            end
            last_pulse = cyc;
            pulse_cnt++;
        end
    end

    // Drive one write for one clock; called just after a falling edge.
    task automatic push_cycle(input logic rs, input logic [7:0] d, input bit acc,
                              input int gap, input bit lat);
        in_wenable = 1'b1;
        in_rs      = rs;
        in_wdata   = d;
        if (acc) sb.push_back('{rs, d, gap, (lat ? cyc + 2 : -1)});
        @(negedge clk);
        in_wenable = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int c0;
    int pc;
    int lvl_exp[6] = '{0, 1, 1, 2, 3, 4};
    int rdy_exp[6] = '{1, 1, 1, 1, 1, 0};

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_level", int'(fifo_level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_wdata", int'(lcd_wdata), 0);
        check("rst_lcd_wenable", int'(lcd_wenable), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Scenario 1: single data write, latency and return to idle
        c0 = cyc;
        push_cycle(1'b1, 8'h41, 1'b1, 0, 1'b1);
        wait_idle("s1_idle_timeout");
        check("s1_idle_cycle", cyc, c0 + 7);
        check("s1_sb_empty", sb.size(), 0);

        // Scenario 2: back-to-back data writes, 6-cycle spacing
        push_cycle(1'b1, 8'h48, 1'b1, 0, 1'b0);
        push_cycle(1'b1, 8'h49, 1'b1, SW + 2, 1'b0);
        push_cycle(1'b1, 8'h4A, 1'b1, SW + 2, 1'b0);
        wait_idle("s2_idle_timeout");
        check("s2_sb_empty", sb.size(), 0);

        // Scenario 3: clear/home use the long wait, 0x00 and data the short
        push_cycle(1'b0, 8'h01, 1'b1, 0, 1'b0);
        push_cycle(1'b1, 8'h30, 1'b1, LW + 2, 1'b0);
        push_cycle(1'b0, 8'h00, 1'b1, SW + 2, 1'b0);
        push_cycle(1'b1, 8'h31, 1'b1, SW + 2, 1'b0);
        wait_idle("s3a_idle_timeout");
        push_cycle(1'b0, 8'h02, 1'b1, 0, 1'b0);
        push_cycle(1'b1, 8'h32, 1'b1, LW + 2, 1'b0);
        push_cycle(1'b0, 8'h03, 1'b1, SW + 2, 1'b0);
        push_cycle(1'b1, 8'h33, 1'b1, LW + 2, 1'b0);
        wait_idle("s3b_idle_timeout");
        check("s3_sb_empty", sb.size(), 0);

        // Scenario 4: six consecutive writes, the sixth hits a full queue
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s4_ready_%0d", i), int'(in_ready), rdy_exp[i]);
            check($sformatf("s4_level_%0d", i), int'(fifo_level), lvl_exp[i]);
            push_cycle(1'b1, 8'(8'h60 + i), (i < 5), (i == 0) ? 0 : SW + 2, 1'b0);
        end
        check("s4_overflow", int'(overflow), 1);
        check("s4_level_full", int'(fifo_level), 4);
        check("s4_ready_full", int'(in_ready), 0);
        pc = pulse_cnt;
        wait_idle("s4_idle_timeout");
        check("s4_pulses", pulse_cnt - pc + 1, 5);
        check("s4_overflow_sticky", int'(overflow), 1);
        check("s4_sb_empty", sb.size(), 0);

        // Scenario 5: reset during WAIT drops the two queued entries
        push_cycle(1'b1, 8'h50, 1'b1, 0, 1'b0);
        push_cycle(1'b1, 8'h51, 1'b0, 0, 1'b0);
        push_cycle(1'b1, 8'h52, 1'b0, 0, 1'b0);
        check("s5_level_pre", int'(fifo_level), 2);
        check("s5_busy_pre", int'(busy), 1);
        rst        = 1'b1;
        in_wenable = 1'b1;  // must be ignored while in reset
        in_rs      = 1'b1;
        in_wdata   = 8'h5F;
        @(negedge clk);
        rst        = 1'b0;
        in_wenable = 1'b0;
        check("s5_level", int'(fifo_level), 0);
        check("s5_busy", int'(busy), 0);
        check("s5_overflow", int'(overflow), 0);
        check("s5_in_ready", int'(in_ready), 1);
        check("s5_lcd_rs", int'(lcd_rs), 0);
        check("s5_lcd_wdata", int'(lcd_wdata), 0);
        pc = pulse_cnt;
        repeat (20) @(negedge clk);
        check("s5_no_pulse", pulse_cnt, pc);
        check("s5_level_post", int'(fifo_level), 0);

        // Scenario 6: push on the same edge as a pop at level 2
        push_cycle(1'b1, 8'h70, 1'b1, 0, 1'b0);
        push_cycle(1'b1, 8'h71, 1'b1, SW + 2, 1'b0);
        push_cycle(1'b1, 8'h72, 1'b1, SW + 2, 1'b0);
        for (int n = 0; n < 20 && cyc != last_pulse + 5; n++) @(negedge clk);
        check("s6_sync", cyc, last_pulse + 5);
        check("s6_level_before", int'(fifo_level), 2);
        push_cycle(1'b1, 8'h73, 1'b1, SW + 2, 1'b0);
        check("s6_level_after", int'(fifo_level), 2);
        wait_idle("s6_idle_timeout");

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_write_pacer.md
LCD_WRITE_PACER -- requirements
Module: lcd_write_pacer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-003 Parameter SHORT_WAIT, default 2000: idle cycles after a normal write (40 us at 50 MHz).
REQ-004 Parameter LONG_WAIT, default 76000: idle cycles after a clear or home command (1.52 ms at 50 MHz).
REQ-005 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port in_wenable, input, 1 bit: bus write strobe, one request per cycle high.
REQ-008 Port in_rs, input, 1 bit: register select for the request (0 = command, 1 = data).
REQ-009 Port in_wdata, input, 8 bits: byte for the request.
REQ-010 Port in_ready, output, 1 bit: queue not full.
REQ-011 Port fifo_level, output, $clog2(DEPTH)+1 bits: current queue occupancy.
REQ-012 Port busy, output, 1 bit: queue non-empty or FSM not in IDLE.
REQ-013 Port overflow, output, 1 bit: sticky flag; a write arrived while full.
REQ-014 Port lcd_rs, output, 1 bit: register select to the downstream LCD controller.
REQ-015 Port lcd_wdata, output, 8 bits: byte to the downstream LCD controller.
REQ-016 Port lcd_wenable, output, 1 bit: single-cycle write strobe to the downstream LCD controller.

Function
REQ-017 Push SHALL occur when in_wenable=1 and in_ready=1; the {in_rs, in_wdata} pair is stored at the queue tail.
REQ-018 When in_wenable=1 and in_ready=0, the write SHALL be dropped, queue state SHALL be unchanged, and overflow SHALL be set to 1.
REQ-019 overflow SHALL stay set until rst.
REQ-020 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-021 IDLE: if the queue is non-empty at the clock edge, the FSM SHALL pop the head, register it onto lcd_rs/lcd_wdata, and go to ISSUE; otherwise it stays in IDLE.
REQ-022 ISSUE SHALL last exactly 1 cycle; lcd_wenable=1 only in ISSUE, and the FSM goes to WAIT with the counter loaded.
REQ-023 WAIT SHALL last exactly SHORT_WAIT or LONG_WAIT cycles, then return to IDLE.
REQ-024 The long wait SHALL apply when lcd_rs=0 and lcd_wdata is 0x01, 0x02 or 0x03; 0x00 and all data writes use the short wait.
REQ-025 lcd_rs/lcd_wdata SHALL hold their value from ISSUE until the next pop.
REQ-026 Latency: a push on edge k into an empty, IDLE block SHALL produce lcd_wenable=1 in the cycle after edge k+1.
REQ-027 With the queue backed up, rising edges of lcd_wenable SHALL be exactly W+2 cycles apart, where W is the wait of the earlier entry.
REQ-028 A simultaneous push and pop SHALL leave fifo_level unchanged, with the order preserved.
REQ-029 A pop SHALL only read entries present before the current edge; there is no bypass from an empty queue.
REQ-030 When the queue is full, in_ready SHALL be 0 in the same cycle, and becomes 1 in the cycle after a pop.
REQ-031 The wait counter SHALL be at least $clog2(max(SHORT_WAIT, LONG_WAIT))+1 bits wide and SHALL never wrap.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL go to IDLE, empty the queue (fifo_level=0), and clear the counter.
REQ-033 On the same edge, outputs SHALL become in_ready=1, busy=0, overflow=0, lcd_rs=0, lcd_wdata=0x00 and lcd_wenable=0.
REQ-034 Reset during ISSUE or WAIT SHALL abort the transfer; no further lcd_wenable pulse occurs for queued entries.
REQ-035 in_wenable SHALL be ignored in any cycle where rst=1.

Structure
REQ-036 Shared package lcd_pkg SHALL hold the FSM state encoding and the constants LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02.
REQ-037 The queue SHALL be a separate sub-module sync_fifo, parameterised by width 9 and DEPTH, with push, pop, full, empty and level.
REQ-038 The FSM, counter and wait selection SHALL live in lcd_write_pacer.

Verification (bench parameters SHORT_WAIT=4, LONG_WAIT=10, DEPTH=4)
REQ-039 Scenario 1: push (rs=1, 0x41) into an idle block at edge k -> lcd_wenable=1 for one cycle after edge k+1, with lcd_rs=1 and lcd_wdata=0x41; busy=0 after 4 wait cycles plus 1.
REQ-040 Scenario 2: back-to-back pushes 0x48, 0x49, 0x4A (rs=1) -> three pulses in order, spaced exactly 6 cycles apart.
REQ-041 Scenario 3: push (rs=0, 0x01) then (rs=1, 0x30) -> second pulse exactly 12 cycles after the first; (rs=0, 0x00) -> 6-cycle spacing.
REQ-042 Scenario 4: 6 pushes on consecutive cycles -> in_ready=0 once level reaches 4, the surplus writes are dropped, overflow=1, and exactly 5 pulses occur (1 popped early plus 4 queued).
REQ-043 Scenario 5: rst asserted for 1 cycle during WAIT with 2 entries queued -> next cycle level=0, busy=0, overflow=0, and no lcd_wenable pulse for 20 cycles.
REQ-044 Scenario 6: push and pop on the same edge at level 2 -> level stays 2 and the output order matches the input order.
